// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl_pkg
//  Brief    : Shared types and constants for the pipeline stall/flush
//             sequencer (memory FSM states, hazard causes, x0 register id).
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Data-memory handshake FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } mem_state_e;

    // Architectural zero register never creates a dependency
    localparam logic [4:0] REG_X0 = 5'd0;

    // Hazard cause, encoded in rising priority order
    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_LOAD_USE   = 2'd1,
        CAUSE_MISPREDICT = 2'd2,
        CAUSE_MEM_STALL  = 2'd3
    } hazard_cause_e;

    // Resolve simultaneous hazards: memory wait beats mispredict beats load-use
    function automatic hazard_cause_e hazard_cause(
        input logic mem_stall,
        input logic mispredict,
        input logic load_use
    );
        if (mem_stall)       return CAUSE_MEM_STALL;
        else if (mispredict) return CAUSE_MISPREDICT;
        else if (load_use)   return CAUSE_LOAD_USE;
        else                 return CAUSE_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_mem_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl_mem_fsm
//  Brief    : Data-memory request handshake. Tracks consecutive wait cycles,
//             raises the memory stall and latches a sticky timeout error.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl_mem_fsm
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic Clk_i,
    input  logic Rst_ni,
    input  logic MEM_Req_i,
    input  logic DMem_Ack_i,
    output logic DMem_Req_o,
    output logic MemStall_o,
    output logic Err_o
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    mem_state_e state_q;
    logic [7:0] wait_cnt_q;

    // Handshake FSM with wait-cycle counter; ERR is left only through reset
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (MEM_Req_i && !DMem_Ack_i) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (DMem_Ack_i) begin
                        state_q    <= RUN;
                        wait_cnt_q <= 8'd0;
                    end else if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_q    <= ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    // Request passes straight through unless the memory has been given up on;
    // outputs are held low for the whole time reset is asserted
    assign DMem_Req_o = Rst_ni && MEM_Req_i && (state_q != ERR);
    assign MemStall_o = Rst_ni && ((state_q == ERR) || (MEM_Req_i && !DMem_Ack_i));
    assign Err_o      = Rst_ni && (state_q == ERR);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Brief    : Stall/flush sequencer for the 5-stage RV32I pipeline. Resolves
//             memory wait, EX mispredict and ID load-use hazards in priority
//             order. Define PIPELINE_CTRL_PERF_EN to build the saturating
//             stall-cycle and flush performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             Clk_i,
    input  logic             Rst_ni,
    input  logic [4:0]       ID_Rs1_i,
    input  logic [4:0]       ID_Rs2_i,
    input  logic             ID_UsesRs1_i,
    input  logic             ID_UsesRs2_i,
    input  logic [4:0]       EX_Rd_i,
    input  logic             EX_MemRdEn_i,
    input  logic             EX_Mispredict_i,
    input  logic             MEM_Req_i,
    input  logic             DMem_Ack_i,
    output logic             DMem_Req_o,
    output logic             PC_Stall_o,
    output logic             PC_Redirect_o,
    output logic             IF_ID_Stall_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Stall_o,
    output logic             ID_EX_Flush_o,
    output logic             EX_MEM_Stall_o,
    output logic             MEM_WB_Bubble_o,
    output logic             Err_o,
    output logic [CNT_W-1:0] Perf_StallCyc_o,
    output logic [CNT_W-1:0] Perf_Flush_o
);

    logic          mem_stall;
    logic          rs1_hit;
    logic          rs2_hit;
    logic          load_use;
    hazard_cause_e cause;

    pipeline_ctrl_mem_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_fsm (
        .Clk_i      (Clk_i),
        .Rst_ni     (Rst_ni),
        .MEM_Req_i  (MEM_Req_i),
        .DMem_Ack_i (DMem_Ack_i),
        .DMem_Req_o (DMem_Req_o),
        .MemStall_o (mem_stall),
        .Err_o      (Err_o)
    );

    // A load in EX feeding a register the ID instruction actually reads
    assign rs1_hit  = ID_UsesRs1_i && (ID_Rs1_i == EX_Rd_i);
    assign rs2_hit  = ID_UsesRs2_i && (ID_Rs2_i == EX_Rd_i);
    assign load_use = EX_MemRdEn_i && (EX_Rd_i != REG_X0) && (rs1_hit || rs2_hit);

    assign cause = Rst_ni ? hazard_cause(mem_stall, EX_Mispredict_i, load_use) : CAUSE_NONE;

    // Map the winning hazard onto the pipeline-register controls
    always_comb begin
        PC_Stall_o      = 1'b0;
        PC_Redirect_o   = 1'b0;
        IF_ID_Stall_o   = 1'b0;
        IF_ID_Flush_o   = 1'b0;
        ID_EX_Stall_o   = 1'b0;
        ID_EX_Flush_o   = 1'b0;
        EX_MEM_Stall_o  = 1'b0;
        MEM_WB_Bubble_o = 1'b0;
        case (cause)
            CAUSE_MEM_STALL: begin
                // Freeze everything up to EX/MEM; a mispredict in EX is kept
                // and acted on once memory releases the pipe
                PC_Stall_o      = 1'b1;
                IF_ID_Stall_o   = 1'b1;
                ID_EX_Stall_o   = 1'b1;
                EX_MEM_Stall_o  = 1'b1;
                MEM_WB_Bubble_o = 1'b1;
            end
            CAUSE_MISPREDICT: begin
                // Younger instructions in IF and ID are wrong-path
                PC_Redirect_o   = 1'b1;
                IF_ID_Flush_o   = 1'b1;
                ID_EX_Flush_o   = 1'b1;
            end
            CAUSE_LOAD_USE: begin
                // Hold the consumer in ID and push one bubble into EX
                PC_Stall_o      = 1'b1;
                IF_ID_Stall_o   = 1'b1;
                ID_EX_Flush_o   = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef PIPELINE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters of stalled-PC cycles and mispredict redirects
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (PC_Stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (PC_Redirect_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign Perf_StallCyc_o = stall_cnt_q;
    assign Perf_Flush_o    = flush_cnt_q;
`else
    assign Perf_StallCyc_o = '0;
    assign Perf_Flush_o    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_ctrl
//  Brief    : Self-checking bench for pipeline_ctrl: single-cycle hazard
//             vector table plus memory wait, timeout and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 32;

    // Output vector bit positions
    localparam logic [9:0] B_DREQ = 10'd1 << 9;
    localparam logic [9:0] B_PCS  = 10'd1 << 8;
    localparam logic [9:0] B_RED  = 10'd1 << 7;
    localparam logic [9:0] B_IFS  = 10'd1 << 6;
    localparam logic [9:0] B_IFF  = 10'd1 << 5;
    localparam logic [9:0] B_IDS  = 10'd1 << 4;
    localparam logic [9:0] B_IDF  = 10'd1 << 3;
    localparam logic [9:0] B_EXS  = 10'd1 << 2;
    localparam logic [9:0] B_BUB  = 10'd1 << 1;
    localparam logic [9:0] B_ERR  = 10'd1 << 0;

    localparam logic [9:0] O_NONE = 10'd0;
    localparam logic [9:0] O_LU   = B_PCS | B_IFS | B_IDF;
    localparam logic [9:0] O_MP   = B_RED | B_IFF | B_IDF;
    localparam logic [9:0] O_MS   = B_PCS | B_IFS | B_IDS | B_EXS | B_BUB;

`ifdef PIPELINE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] EXP_STALLS  = 32'd10;
    localparam logic [CNT_W-1:0] EXP_FLUSHES = 32'd2;
`else
    localparam logic [CNT_W-1:0] EXP_STALLS  = 32'd0;
    localparam logic [CNT_W-1:0] EXP_FLUSHES = 32'd0;
`endif

    logic             Clk_i = 1'b0;
    logic             Rst_ni;
    logic [4:0]       ID_Rs1_i, ID_Rs2_i, EX_Rd_i;
    logic             ID_UsesRs1_i, ID_UsesRs2_i, EX_MemRdEn_i, EX_Mispredict_i;
    logic             MEM_Req_i, DMem_Ack_i;
    logic             DMem_Req_o, PC_Stall_o, PC_Redirect_o, IF_ID_Stall_o, IF_ID_Flush_o;
    logic             ID_EX_Stall_o, ID_EX_Flush_o, EX_MEM_Stall_o, MEM_WB_Bubble_o, Err_o;
    logic [CNT_W-1:0] Perf_StallCyc_o, Perf_Flush_o;
    logic [9:0]       w_out;

    int total = 0;
    int bad   = 0;

    always #5 Clk_i = ~Clk_i;

    pipeline_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .Clk_i           (Clk_i),
        .Rst_ni          (Rst_ni),
        .ID_Rs1_i        (ID_Rs1_i),
        .ID_Rs2_i        (ID_Rs2_i),
        .ID_UsesRs1_i    (ID_UsesRs1_i),
        .ID_UsesRs2_i    (ID_UsesRs2_i),
        .EX_Rd_i         (EX_Rd_i),
        .EX_MemRdEn_i    (EX_MemRdEn_i),
        .EX_Mispredict_i (EX_Mispredict_i),
        .MEM_Req_i       (MEM_Req_i),
        .DMem_Ack_i      (DMem_Ack_i),
        .DMem_Req_o      (DMem_Req_o),
        .PC_Stall_o      (PC_Stall_o),
        .PC_Redirect_o   (PC_Redirect_o),
        .IF_ID_Stall_o   (IF_ID_Stall_o),
        .IF_ID_Flush_o   (IF_ID_Flush_o),
        .ID_EX_Stall_o   (ID_EX_Stall_o),
        .ID_EX_Flush_o   (ID_EX_Flush_o),
        .EX_MEM_Stall_o  (EX_MEM_Stall_o),
        .MEM_WB_Bubble_o (MEM_WB_Bubble_o),
        .Err_o           (Err_o),
        .Perf_StallCyc_o (Perf_StallCyc_o),
        .Perf_Flush_o    (Perf_Flush_o)
    );

    assign w_out = {DMem_Req_o, PC_Stall_o, PC_Redirect_o, IF_ID_Stall_o, IF_ID_Flush_o,
                    ID_EX_Stall_o, ID_EX_Flush_o, EX_MEM_Stall_o, MEM_WB_Bubble_o, Err_o};

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       memrd;
        logic       mispred;
        logic       memreq;
        logic       ack;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t table_v[13];

    function automatic vec_t mk(string name, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic [4:0] rd, logic memrd, logic mispred, logic memreq,
                                logic ack, logic [9:0] exp);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
        v.memrd = memrd; v.mispred = mispred; v.memreq = memreq; v.ack = ack; v.exp = exp;
        return v;
    endfunction

    // Memory/mispredict-only vector with no register dependency
    function automatic vec_t mem_v(string name, logic mispred, logic memreq, logic ack,
                                   logic [9:0] exp);
        return mk(name, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, mispred, memreq, ack, exp);
    endfunction

    task automatic apply(input vec_t v);
        ID_Rs1_i = v.rs1; ID_UsesRs1_i = v.u1; ID_Rs2_i = v.rs2; ID_UsesRs2_i = v.u2;
        EX_Rd_i = v.rd; EX_MemRdEn_i = v.memrd; EX_Mispredict_i = v.mispred;
        MEM_Req_i = v.memreq; DMem_Ack_i = v.ack;
    endtask

    task automatic push_exp(input string name, input logic [9:0] exp);
        sb_t t;
        t.name = name;
        t.exp  = exp;
        sb_q.push_back(t);
    endtask

    task automatic check_outputs();
        sb_t t;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: no expected entry for out=%b", w_out);
        end else begin
            t = sb_q.pop_front();
            if (w_out !== t.exp) begin
                bad++;
                $display("FAIL %s: out=%b required=%b", t.name, w_out, t.exp);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [CNT_W-1:0] got,
                             input logic [CNT_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d required=%0d", name, got, want);
        end
    endtask

    // Drive one cycle, compare at the falling edge, advance past the rising edge
    task automatic run_vec(input vec_t v);
        apply(v);
        push_exp(v.name, v.exp);
        @(negedge Clk_i);
        check_outputs();
        @(posedge Clk_i);
        #1;
    endtask

    // Assert reset mid-cycle with busy inputs, check outputs drop, then release
    task automatic async_reset(input string name);
        apply(mk(name, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, O_NONE));
        #1;
        Rst_ni = 1'b0;
        push_exp(name, O_NONE);
        #1;
        check_outputs();
        apply(mem_v("idle", 1'b0, 1'b0, 1'b0, O_NONE));
        @(negedge Clk_i);
        Rst_ni = 1'b1;
        @(posedge Clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        table_v[0]  = mk("idle",          5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        table_v[1]  = mk("lu_rs1",        5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        table_v[2]  = mk("lu_x0",         5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        table_v[3]  = mk("lu_rs1_unused", 5'd5, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        table_v[4]  = mk("lu_rs2",        5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        table_v[5]  = mk("lu_unused_both",5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        table_v[6]  = mk("lu_no_match",   5'd6, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        table_v[7]  = mk("not_load",      5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        table_v[8]  = mk("mp_over_lu",    5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_MP);
        table_v[9]  = mk("mp_only",       5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_MP);
        table_v[10] = mk("mem_ack_same",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, B_DREQ);
        table_v[11] = mk("mem_ack_mp",    5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, B_DREQ | O_MP);
        table_v[12] = mk("mem_ack_lu",    5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, B_DREQ | O_LU);

        // Reset held with every hazard input active: all outputs low
        Rst_ni = 1'b0;
        apply(mk("reset_hold", 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, O_NONE));
        #2;
        push_exp("reset_hold", O_NONE);
        check_outputs();
        check_val("reset_perf_stall", Perf_StallCyc_o, '0);
        check_val("reset_perf_flush", Perf_Flush_o, '0);
        apply(mem_v("idle", 1'b0, 1'b0, 1'b0, O_NONE));
        @(negedge Clk_i);
        Rst_ni = 1'b1;
        @(posedge Clk_i);
        #1;

        // Single-cycle hazard combinations in RUN
        for (int i = 0; i < 13; i++) begin
            run_vec(table_v[i]);
        end

        // Ack arrives on the fourth request cycle: three stall cycles
        for (int i = 0; i < 3; i++) run_vec(mem_v("wait3_stall", 1'b0, 1'b1, 1'b0, B_DREQ | O_MS));
        run_vec(mem_v("wait3_ack", 1'b0, 1'b1, 1'b1, B_DREQ));
        run_vec(mem_v("wait3_after", 1'b0, 1'b0, 1'b0, O_NONE));

        // Mispredict held in frozen EX is acted on in the first unstalled cycle
        for (int i = 0; i < 2; i++) run_vec(mem_v("mp_in_wait", 1'b1, 1'b1, 1'b0, B_DREQ | O_MS));
        run_vec(mem_v("mp_release", 1'b1, 1'b1, 1'b1, B_DREQ | O_MP));
        run_vec(mem_v("mp_after", 1'b0, 1'b0, 1'b0, O_NONE));

        // Reset in the middle of a wait abandons the request
        for (int i = 0; i < 2; i++) run_vec(mem_v("pre_rst_wait", 1'b0, 1'b1, 1'b0, B_DREQ | O_MS));
        async_reset("rst_mid_wait");
        run_vec(mem_v("post_rst_idle", 1'b0, 1'b0, 1'b0, O_NONE));

        // Never acked: RUN cycle plus MEM_TIMEOUT wait cycles, then ERR
        for (int i = 0; i < MEM_TIMEOUT + 1; i++)
            run_vec(mem_v("tmo_wait", 1'b0, 1'b1, 1'b0, B_DREQ | O_MS));
        run_vec(mem_v("tmo_err", 1'b0, 1'b1, 1'b0, O_MS | B_ERR));
        run_vec(mem_v("err_sticky_mp", 1'b1, 1'b0, 1'b0, O_MS | B_ERR));
        run_vec(mk("err_sticky_lu", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, O_MS | B_ERR));
        async_reset("rst_in_err");
        run_vec(mem_v("post_err_idle", 1'b0, 1'b0, 1'b0, O_NONE));
        check_val("perf_stall_cleared", Perf_StallCyc_o, '0);
        check_val("perf_flush_cleared", Perf_Flush_o, '0);

        // Ten load-use stall cycles and two redirects
        for (int i = 0; i < 10; i++) run_vec(table_v[1]);
        for (int i = 0; i < 2; i++) run_vec(table_v[9]);
        run_vec(table_v[0]);
        check_val("perf_stall_cycles", Perf_StallCyc_o, EXP_STALLS);
        check_val("perf_flushes", Perf_Flush_o, EXP_FLUSHES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
